// File: rtl/hyperbus_cdc_src_chan.sv
// Writer half of a gray-pointer async FIFO: beats land in an exported register array, gray write pointer published.
// Push visible one cycle after acceptance; ready is registered-state only, credit returns SyncStages cycles after rptr moves.
module hyperbus_cdc_src_chan #(
  parameter int DataWidth  = 32,
  parameter int LogDepth   = 3,
  parameter int SyncStages = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [DataWidth-1:0]              src_data_i,
  input  logic                              src_valid_i,
  output logic                              src_ready_o,
  output logic [DataWidth*(1<<LogDepth)-1:0] async_data_o,
  output logic [LogDepth:0]                 async_wptr_o,
  input  logic [LogDepth:0]                 async_rptr_i,
  output logic [LogDepth:0]                 fill_o,
  output logic                              empty_o
);

  localparam int Depth    = 1 << LogDepth;
  localparam int PtrWidth = LogDepth + 1;
  localparam logic [PtrWidth-1:0] PtrOne = PtrWidth'(1);
  localparam logic [PtrWidth-1:0] PtrMsb = PtrOne << LogDepth;

  logic [PtrWidth-1:0]  wptr_q;
  logic [PtrWidth-1:0]  wptr_gray_q;
  logic [PtrWidth-1:0]  wptr_inc;
  logic [PtrWidth-1:0]  rptr_bin;
  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrWidth-1:0]  rptr_sync_q [SyncStages];
  logic                 full;
  logic                 push;

  function automatic logic [PtrWidth-1:0] bin2gray(input logic [PtrWidth-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PtrWidth-1:0] gray2bin(input logic [PtrWidth-1:0] g);
    logic [PtrWidth-1:0] b;
    b[PtrWidth-1] = g[PtrWidth-1];
    for (int i = PtrWidth - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Full and empty differ only in the pointer MSB (wrap bit).
  assign rptr_bin     = gray2bin(rptr_sync_q[SyncStages-1]);
  assign full         = (wptr_q == (rptr_bin ^ PtrMsb));
  assign src_ready_o  = !full;
  assign push         = src_valid_i && !full;
  assign wptr_inc     = wptr_q + PtrOne;
  assign fill_o       = wptr_q - rptr_bin;
  assign empty_o      = (fill_o == '0);
  assign async_wptr_o = wptr_gray_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q      <= '0;
      wptr_gray_q <= '0;
    end else if (push) begin
      wptr_q      <= wptr_inc;
      wptr_gray_q <= bin2gray(wptr_inc);
    end
  end

  // Slot and pointer change on the same edge; the far side's pointer sync hides the data settling.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wptr_q[LogDepth-1:0]] <= src_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SyncStages; i++) begin
        rptr_sync_q[i] <= '0;
      end
    end else begin
      rptr_sync_q[0] <= async_rptr_i;
      for (int i = 1; i < SyncStages; i++) begin
        rptr_sync_q[i] <= rptr_sync_q[i-1];
      end
    end
  end

  for (genvar k = 0; k < Depth; k++) begin : g_slot
    assign async_data_o[k*DataWidth +: DataWidth] = mem_q[k];
  end

  // A read pointer running ahead of the write pointer shows up as an impossible fill level.
  fill_legal_a: assert property (@(posedge clk_i) disable iff (rst_i) fill_o <= PtrMsb);

endmodule

// File: tb/tb_hyperbus_cdc_src_chan.sv
// Randomized bench for hyperbus_cdc_src_chan with a queue-based FIFO model and a per-cycle compare process.
module tb_hyperbus_cdc_src_chan;
  localparam int DW = 32;
  localparam int LD = 3;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] src_data;
  logic          src_valid;
  logic          src_ready;
  logic [DW*8-1:0] async_data;
  logic [3:0]    async_wptr;
  logic [3:0]    async_rptr;
  logic [3:0]    fill;
  logic          empty;

  // Reader side of the system: binary read count, published as gray.
  logic [3:0]    rd_bin;
  int            rd_total;
  assign async_rptr = rd_bin ^ (rd_bin >> 1);

  always #5 clk = ~clk;

  hyperbus_cdc_src_chan #(.DataWidth(DW), .LogDepth(LD), .SyncStages(SS)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .src_data_i   (src_data),
    .src_valid_i  (src_valid),
    .src_ready_o  (src_ready),
    .async_data_o (async_data),
    .async_wptr_o (async_wptr),
    .async_rptr_i (async_rptr),
    .fill_o       (fill),
    .empty_o      (empty)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  int max_fill = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Model: write count, slot contents, beats in flight, read pointer as seen SS edges late.
  logic [3:0]    m_w = '0;
  logic [DW-1:0] m_mem [8];
  logic [3:0]    m_rq [$];
  logic [DW-1:0] sent [$];
  int            acc_cnt = 0;

  function automatic logic [3:0] m_fill();
    return m_w - m_rq[0];
  endfunction

  initial begin
    foreach (m_mem[i]) m_mem[i] = '0;
    repeat (SS) m_rq.push_back(4'd0);
  end

  always @(posedge clk) begin
    if (rst) begin
      m_w = '0;
      foreach (m_mem[i]) m_mem[i] = '0;
      m_rq = {};
      repeat (SS) m_rq.push_back(4'd0);
      sent = {};
      acc_cnt = 0;
    end else begin
      if (src_valid && m_fill() != 4'd8) begin
        m_mem[m_w % 8] = src_data;
        m_w = m_w + 4'd1;
        sent.push_back(src_data);
        acc_cnt++;
      end
      m_rq.push_back(rd_bin);
      m_rq.pop_front();
    end
  end

  logic [DW*8-1:0] exp_data;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 8; i++) exp_data[i*DW +: DW] = m_mem[i];
      chk("wptr", async_wptr, m_w ^ (m_w >> 1));
      chk("data", async_data, exp_data);
      chk("fill", fill, m_fill());
      chk("empty", empty, m_fill() == 4'd0);
      chk("ready", src_ready, m_fill() != 4'd8);
      if (int'(fill) > max_fill) max_fill = int'(fill);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] slot(input int k);
    return async_data[k*DW +: DW];
  endfunction

  task automatic rd_adv();
    int idx;
    idx = int'(rd_bin[2:0]);
    chk("read_order", slot(idx), sent[0]);
    void'(sent.pop_front());
    rd_bin = rd_bin + 4'd1;
    rd_total++;
  endtask

  logic [3:0] gseq [8];
  int hist [$];
  int start;
  int cyc;

  initial begin
    gseq = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};
    rst = 1'b1; src_valid = 1'b1; src_data = 32'hDEAD; rd_bin = '0; rd_total = 0;

    // Reset with a beat presented: nothing is pushed.
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_wptr", async_wptr, 4'd0);
    chk("rst_ready", src_ready, 1'b1);
    chk("rst_empty", empty, 1'b1);
    chk("rst_data", async_data, '0);
    rst = 1'b0; src_valid = 1'b0;
    tick();

    // Fill to full with rptr held at 0.
    for (int k = 0; k < 8; k++) begin
      src_valid = 1'b1; src_data = 32'hA0 + k;
      tick();
      chk("fill_gray", async_wptr, gseq[k]);
    end
    chk("full_fill", fill, 4'd8);
    chk("full_ready", src_ready, 1'b0);
    for (int k = 0; k < 8; k++) chk("slot_val", slot(k), 32'hA0 + k);
    src_data = 32'hA8;
    tick();
    chk("held_off", async_wptr, 4'd12);

    // Credit return: ready rises SS cycles after the rptr change.
    rd_adv();
    tick();
    chk("credit_s1_ready", src_ready, 1'b0);
    tick();
    chk("credit_s2_ready", src_ready, 1'b1);
    chk("credit_s2_wptr", async_wptr, 4'd12);
    tick();
    chk("credit_wptr", async_wptr, 4'd13);
    chk("credit_slot0", slot(0), 32'hA8);
    chk("credit_refull", src_ready, 1'b0);

    // Valid and credit together while full: exactly one beat once ready rises.
    src_data = 32'hA9;
    rd_adv();
    tick();
    chk("sim_noacc", async_wptr, 4'd13);
    tick();
    chk("sim_wait", async_wptr, 4'd13);
    chk("sim_ready", src_ready, 1'b1);
    tick();
    src_valid = 1'b0;
    chk("sim_acc", async_wptr, 4'd15);
    chk("sim_slot1", slot(1), 32'hA9);
    chk("sim_refull", src_ready, 1'b0);

    // Wrap-around: 40 random beats, reader follows the write count 3 cycles late.
    hist = {acc_cnt, acc_cnt, acc_cnt};
    start = acc_cnt; cyc = 0;
    while (acc_cnt - start < 40 && cyc < 2000) begin
      src_valid = ($urandom_range(0, 3) != 0);
      src_data  = $urandom;
      if (hist[0] > rd_total && $urandom_range(0, 2) != 0) rd_adv();
      tick(); cyc++;
      hist.push_back(acc_cnt); void'(hist.pop_front());
    end
    src_valid = 1'b0;
    chk("wrap_done", (acc_cnt - start) >= 40, 1'b1);
    cyc = 0;
    while (rd_total < acc_cnt && cyc < 200) begin
      if (hist[0] > rd_total) rd_adv();
      tick(); cyc++;
      hist.push_back(acc_cnt); void'(hist.pop_front());
    end
    chk("drain_done", rd_total == acc_cnt, 1'b1);
    chk("no_leftover", sent.size(), 0);
    chk("fill_max_le8", max_fill <= 8, 1'b1);
    tick(); tick();
    chk("drain_empty", empty, 1'b1);

    // Mid-stream reset with 5 beats pending.
    for (int k = 0; k < 5; k++) begin
      src_valid = 1'b1; src_data = 32'hC0 + k;
      tick();
    end
    chk("pend_fill", fill, 4'd5);
    rst = 1'b1; src_data = 32'hBAD; rd_bin = '0; rd_total = 0;
    tick();
    chk("mrst_wptr", async_wptr, 4'd0);
    chk("mrst_data", async_data, '0);
    chk("mrst_fill", fill, 4'd0);
    chk("mrst_empty", empty, 1'b1);
    chk("mrst_ready", src_ready, 1'b1);
    rst = 1'b0; src_data = 32'h55;
    tick();
    src_valid = 1'b0;
    chk("post_wptr", async_wptr, 4'd1);
    chk("post_slot0", slot(0), 32'h55);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
